// File: rtl/spi_slave_ctrl_if.sv
// spi_slave_ctrl_if: oversampled mode-0 SPI slave committing 32-bit frames to ctrl_reg0 while returning a status word
`timescale 1ns/1ps
module spi_slave_ctrl_if #(
  parameter int FRAME_BITS = 32,
  parameter logic [FRAME_BITS-1:0] CTRL_RESET = '0,
  parameter bit ZERO_FRAME_IS_READ = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spi_sclk,
  input  logic                  spi_ssb,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  output logic                  spi_miso_oe,
  input  logic [FRAME_BITS-1:0] status_in,
  output logic [FRAME_BITS-1:0] ctrl_reg0,
  output logic                  ctrl_wr_stb,
  output logic                  frame_err,
  output logic                  busy
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam logic [5:0] FULL = 6'(FRAME_BITS);
  state_t state;
  logic sclk_s1, sclk_s2, sclk_s3, ssb_s1, ssb_s2, ssb_s3, mosi_s1, mosi_s2;
  logic primed, armed, ovf;
  logic [5:0] bit_cnt;
  logic [FRAME_BITS-1:0] rx_shift, tx_shift;
  logic sclk_rise, sclk_fall, ssb_rise, ssb_fall;
  assign sclk_rise = sclk_s2 & ~sclk_s3;
  assign sclk_fall = ~sclk_s2 & sclk_s3;
  assign ssb_rise = ssb_s2 & ~ssb_s3;
  assign ssb_fall = ~ssb_s2 & ssb_s3;
  always_ff @(posedge clk) begin
    if (rst) begin
      {sclk_s1, sclk_s2, sclk_s3} <= 3'b000;
      {ssb_s1, ssb_s2, ssb_s3} <= 3'b111;
      {mosi_s1, mosi_s2} <= 2'b00;
      primed <= 1'b0;
      armed <= 1'b0;
      ovf <= 1'b0;
      bit_cnt <= '0;
      rx_shift <= '0;
      tx_shift <= '0;
      state <= IDLE;
      ctrl_reg0 <= CTRL_RESET;
      {spi_miso, spi_miso_oe, ctrl_wr_stb, frame_err, busy} <= 5'b0;
    end else begin
      {sclk_s1, sclk_s2, sclk_s3} <= {spi_sclk, sclk_s1, sclk_s2};
      {ssb_s1, ssb_s2, ssb_s3} <= {spi_ssb, ssb_s1, ssb_s2};
      {mosi_s1, mosi_s2} <= {spi_mosi, mosi_s1};
      primed <= 1'b1;
      // a frame already underway when reset released must not be picked up: require ssb seen high first
      armed <= armed | (primed & ssb_s1);
      ctrl_wr_stb <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: if (ssb_fall && armed) begin
          tx_shift <= status_in;
          bit_cnt <= '0;
          ovf <= 1'b0;
          busy <= 1'b1;
          spi_miso_oe <= 1'b1;
          spi_miso <= status_in[FRAME_BITS-1];
          state <= SHIFT;
        end
        SHIFT: if (ssb_rise) state <= DONE;
          else if (sclk_rise) begin
            if (bit_cnt == FULL) ovf <= 1'b1;
            else begin
              rx_shift <= {rx_shift[FRAME_BITS-2:0], mosi_s2};
              bit_cnt <= bit_cnt + 6'd1;
            end
          end else if (sclk_fall) begin
            tx_shift <= {tx_shift[FRAME_BITS-2:0], 1'b0};
            spi_miso <= tx_shift[FRAME_BITS-2];
          end
        DONE: begin
          state <= IDLE;
          busy <= 1'b0;
          spi_miso_oe <= 1'b0;
          spi_miso <= 1'b0;
          if (bit_cnt == FULL && !ovf) begin
            if (!(ZERO_FRAME_IS_READ && rx_shift == '0)) begin
              ctrl_reg0 <= rx_shift;
              ctrl_wr_stb <= 1'b1;
            end
          end else frame_err <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_slave_ctrl_if.sv
// tb_spi_slave_ctrl_if: randomized SPI master with scoreboard queues for commit/error pulses and MISO read-back
`timescale 1ns/1ps
module tb_spi_slave_ctrl_if;
  localparam logic [31:0] CTRL_RESET = 32'h0;
  logic clk = 0, rst = 1, spi_sclk = 0, spi_ssb = 1, spi_mosi = 0;
  logic [31:0] status_in = 0;
  logic spi_miso, spi_miso_oe, ctrl_wr_stb, frame_err, busy;
  logic [31:0] ctrl_reg0;
  typedef struct {bit err; logic [31:0] val;} ev_t;
  typedef struct {bit chk; logic [31:0] val;} rd_t;
  ev_t ev_q[$];
  rd_t rd_q[$];
  ev_t e;
  rd_t r;
  int total = 0, bad = 0, cap_n = 0;
  logic [31:0] model_ctrl = CTRL_RESET, cap_w = 0;
  bit oe_bad = 0;
  longint t_rise = 0, lat;

  spi_slave_ctrl_if #(.FRAME_BITS(32), .CTRL_RESET(CTRL_RESET), .ZERO_FRAME_IS_READ(1'b1)) dut (
    .clk(clk), .rst(rst), .spi_sclk(spi_sclk), .spi_ssb(spi_ssb), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .status_in(status_in), .ctrl_reg0(ctrl_reg0),
    .ctrl_wr_stb(ctrl_wr_stb), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) if (ctrl_wr_stb || frame_err) begin
    if (ev_q.size() == 0) check("unexpected_pulse", {ctrl_wr_stb, frame_err}, 0);
    else begin
      e = ev_q.pop_front();
      check("pulse_kind", {ctrl_wr_stb, frame_err}, e.err ? 2'b01 : 2'b10);
      if (!e.err) check("ctrl_on_stb", ctrl_reg0, e.val);
      lat = ($time - t_rise) / 10;
      total++;
      if (lat > 4) begin
        bad++;
        $display("FAIL pulse_latency: got %0d cycles, required <= 4", lat);
      end
    end
  end

  always @(negedge spi_ssb) begin
    cap_n = 0;
    oe_bad = 0;
  end

  always @(posedge spi_sclk) if (!spi_ssb) begin
    #25;
    if (cap_n < 32) begin
      cap_w = {cap_w[30:0], spi_miso};
      if (spi_miso_oe !== 1'b1) oe_bad = 1;
    end
    cap_n++;
  end

  always @(posedge spi_ssb) if (rd_q.size() != 0) begin
    r = rd_q.pop_front();
    if (r.chk) begin
      check("miso_word", cap_w, r.val);
      check("miso_oe_during_frame", oe_bad, 0);
    end
  end

  task automatic frame(input int nbits, input logic [31:0] word, input logic [31:0] st,
                       input int chg_at, input logic [31:0] st2, input int rst_at);
    if (rst_at >= 0) model_ctrl = CTRL_RESET;
    else if (nbits == 32) begin
      if (word != 0) begin
        ev_q.push_back('{1'b0, word});
        model_ctrl = word;
      end
    end else ev_q.push_back('{1'b1, model_ctrl});
    rd_q.push_back('{(nbits >= 32 && rst_at < 0), st});
    status_in = st;
    spi_ssb = 0;
    #50;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = (i < 32) ? word[31-i] : 1'b1;
      #50 spi_sclk = 1;
      #50 spi_sclk = 0;
      if (i == chg_at) status_in = st2;
      if (i == rst_at) begin
        rst = 1;
        #20 rst = 0;
        #1 check("reset_mid_frame", {ctrl_reg0, busy, spi_miso_oe, spi_miso, ctrl_wr_stb, frame_err}, {CTRL_RESET, 5'b0});
        #9;
      end
    end
    #50;
    t_rise = $time;
    spi_ssb = 1;
    #200;
    check("events_drained", ev_q.size(), 0);
    check("ctrl_reg0_after", ctrl_reg0, model_ctrl);
    check("idle_busy_oe", {busy, spi_miso_oe}, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int r_sel, nb;
    logic [31:0] w;
    #50 rst = 0;
    check("reset_state", {ctrl_reg0, busy, spi_miso_oe, spi_miso, ctrl_wr_stb, frame_err}, {CTRL_RESET, 5'b0});
    #100;
    frame(32, 32'h8010_1234, $urandom, -1, 0, -1);
    frame(32, 32'h0, 32'hA5A5_0F0F, -1, 0, -1);
    frame(16, $urandom, $urandom, -1, 0, -1);
    frame(32, 32'h0006_0001, $urandom, -1, 0, -1);
    frame(33, $urandom, $urandom, -1, 0, -1);
    frame(32, 32'h1357_9BDF, 32'h1111_1111, 10, 32'h2222_2222, -1);
    frame(32, 32'h1234_5678, $urandom, -1, 0, 12);
    frame(32, 32'h0000_00FF, $urandom, -1, 0, -1);
    frame(0, 32'h0, $urandom, -1, 0, -1);
    for (int k = 0; k < 10; k++) begin
      r_sel = $urandom_range(0, 5);
      nb = (r_sel == 0) ? $urandom_range(1, 31) : (r_sel == 1) ? 33 : 32;
      w = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      frame(nb, w, $urandom, -1, 0, -1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
